// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and its environment (gate under test,
// golden table source and the controller issuing start).
interface truth_table_sweeper_if #(
  parameter int N_IN = 2
) ();
  logic                 start;
  logic [N_IN-1:0]      stim;
  logic                 s;
  logic [2**N_IN-1:0]   expected;
  logic [2**N_IN-1:0]   table_out;
  logic                 busy;
  logic                 done;
  logic                 mismatch;
  logic [N_IN:0]        err_count;

  // master: the sweeper itself, which drives stim and reports results
  modport master (
    input  start, s, expected,
    output stim, table_out, busy, done, mismatch, err_count
  );

  modport slave (
    output start, s, expected,
    input  stim, table_out, busy, done, mismatch, err_count
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a combinational gate through every input vector, captures its output
// after a settle window, and scores the captured truth table against a golden mask.
module truth_table_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  truth_table_sweeper_if.master   bus
);

  localparam int NV    = 2**N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [N_IN-1:0]  LAST_VEC  = N_IN'(NV - 1);
  localparam bit               NO_SETTLE = (SETTLE == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [NV-1:0]     table_q, table_d;
  logic [N_IN:0]     err_q, err_d;
  logic              mismatch_q, mismatch_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Per-entry view of the current vector: the table with s merged into the
  // addressed bit, and whether that bit disagrees with the golden mask.
  logic [NV-1:0]     table_upd;
  logic [NV-1:0]     diff_hit;
  logic              bit_diff;
  logic [N_IN:0]     err_inc;

  for (genvar gi = 0; gi < NV; gi++) begin : g_entry
    logic sel;
    assign sel           = (stim_q == N_IN'(gi));
    assign table_upd[gi] = sel ? bus.s : table_q[gi];
    assign diff_hit[gi]  = sel & (bus.s ^ bus.expected[gi]);
  end

  assign bit_diff = |diff_hit;
  assign err_inc  = err_q + {{N_IN{1'b0}}, bit_diff};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stim_d     = stim_q;
    table_d    = table_q;
    err_d      = err_q;
    mismatch_d = mismatch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          stim_d     = '0;
          cnt_d      = '0;
          table_d    = '0;
          err_d      = '0;
          mismatch_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = NO_SETTLE ? S_SAMPLE : S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        table_d = table_upd;
        err_d   = err_inc;
        // stim is left parked on the last vector rather than wrapping
        if (stim_q == LAST_VEC) begin
          busy_d     = 1'b0;
          done_d     = 1'b1;
          mismatch_d = (err_inc != '0);
          state_d    = S_DONE;
        end else begin
          stim_d  = stim_q + N_IN'(1);
          state_d = NO_SETTLE ? S_SAMPLE : S_WAIT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      stim_q     <= '0;
      table_q    <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stim_q     <= stim_d;
      table_q    <= table_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.stim      = stim_q;
  assign bus.table_out = table_q;
  assign bus.err_count = err_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Three sweepers (SETTLE = 1, 3, 0) driven by directed and random stimulus and
// checked every cycle against a timeline model of the sweep.
module tb_truth_table_sweeper;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [NI];
  logic       start_v [NI];
  logic [3:0] f_v     [NI];
  logic [3:0] exp_v   [NI];

  logic [1:0] stim_w [NI];
  logic [3:0] tbl_w  [NI];
  logic [2:0] err_w  [NI];
  logic       busy_w [NI];
  logic       done_w [NI];
  logic       mis_w  [NI];

  int checks = 0;
  int errors = 0;
  int rand_dones = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int SV = (gi == 0) ? 1 : (gi == 1) ? 3 : 0;
    truth_table_sweeper_if #(.N_IN(2)) ifc ();
    assign ifc.start    = start_v[gi];
    assign ifc.s        = f_v[gi][ifc.stim];
    assign ifc.expected = exp_v[gi];
    assign stim_w[gi]   = ifc.stim;
    assign tbl_w[gi]    = ifc.table_out;
    assign err_w[gi]    = ifc.err_count;
    assign busy_w[gi]   = ifc.busy;
    assign done_w[gi]   = ifc.done;
    assign mis_w[gi]    = ifc.mismatch;
    truth_table_sweeper #(.N_IN(2), .SETTLE(SV)) u_dut (
      .clk   (clk),
      .reset (rst_v[gi]),
      .bus   (ifc.master)
    );
  end

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 0;
  endfunction

  // Model: t counts edges since the accepted start; vector v is captured on
  // edge (v+1)*(SETTLE+1), so t/(SETTLE+1) vectors are in the table at time t.
  typedef struct packed {
    bit       active;
    bit       in_done;
    int       t;
    bit [1:0] stim;
    bit [3:0] tbl;
    bit [2:0] err;
    bit       mis;
    bit       busy;
    bit       done;
  } m_t;

  m_t m [NI];

  function automatic m_t step(input m_t c, input bit r, input bit st,
                              input bit [3:0] f, input bit [3:0] e, input int p);
    m_t n;
    int k;
    bit [3:0] mask;
    n = c;
    if (r) begin
      n = '0;
    end else if (c.in_done) begin
      n.in_done = 1'b0;
      n.done    = 1'b0;
    end else if (c.active) begin
      n.t  = c.t + 1;
      k    = n.t / p;
      mask = 4'((1 << k) - 1);
      n.tbl = f & mask;
      n.err = 3'($countones((f ^ e) & mask));
      if (n.t == 4 * p) begin
        n.active  = 1'b0;
        n.in_done = 1'b1;
        n.done    = 1'b1;
        n.busy    = 1'b0;
        n.mis     = (n.err != 0);
        n.stim    = 2'd3;
      end else begin
        n.stim = 2'(k);
      end
    end else if (st) begin
      n.active = 1'b1;
      n.t      = 0;
      n.stim   = 2'd0;
      n.tbl    = 4'd0;
      n.err    = 3'd0;
      n.mis    = 1'b0;
      n.busy   = 1'b1;
    end
    return n;
  endfunction

  initial begin
    for (int i = 0; i < NI; i++) m[i] = '0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++)
      m[i] <= step(m[i], rst_v[i], start_v[i], f_v[i], exp_v[i], settle_of(i) + 1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      checks += 6;
      if (stim_w[i] !== m[i].stim) begin
        errors++; $display("FAIL cyc_stim inst%0d actual %0d expected %0d", i, stim_w[i], m[i].stim);
      end
      if (tbl_w[i] !== m[i].tbl) begin
        errors++; $display("FAIL cyc_table inst%0d actual %b expected %b", i, tbl_w[i], m[i].tbl);
      end
      if (err_w[i] !== m[i].err) begin
        errors++; $display("FAIL cyc_err inst%0d actual %0d expected %0d", i, err_w[i], m[i].err);
      end
      if (busy_w[i] !== m[i].busy) begin
        errors++; $display("FAIL cyc_busy inst%0d actual %b expected %b", i, busy_w[i], m[i].busy);
      end
      if (done_w[i] !== m[i].done) begin
        errors++; $display("FAIL cyc_done inst%0d actual %b expected %b", i, done_w[i], m[i].done);
      end
      if (mis_w[i] !== m[i].mis) begin
        errors++; $display("FAIL cyc_mismatch inst%0d actual %b expected %b", i, mis_w[i], m[i].mis);
      end
      if (done_w[i] === 1'b1) rand_dones++;
    end
  end

  // Gate truth tables built from x=stim[1], y=stim[0].
  function automatic logic [3:0] gate_tt(input int sel);
    logic [3:0] r;
    logic [1:0] vv;
    logic x, y;
    r = '0;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      x = vv[1];
      y = vv[0];
      case (sel)
        0:       r[v] = ~(x & ~y) | (y | x);
        1:       r[v] = x & y;
        2:       r[v] = x | y;
        default: r[v] = ~x;
      endcase
    end
    return r;
  endfunction

  task automatic wait_done(input int i, output int edges);
    edges = 0;
    while (done_w[i] !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic sweep(input int i, input int sel, input logic [3:0] e, output int edges);
    @(negedge clk);
    f_v[i]     = gate_tt(sel);
    exp_v[i]   = e;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    wait_done(i, edges);
  endtask

  initial begin
    int n;
    int k;
    int seen;
    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b1; start_v[i] = 1'b0; f_v[i] = '0; exp_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset_stim", stim_w[0], 0);
    check("reset_busy", busy_w[0], 0);
    for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;

    // constant-1 gate against all-ones
    sweep(0, 0, 4'hF, n);
    check("t1_latency", n, 8);
    check("t1_table", tbl_w[0], 4'hF);
    check("t1_err", err_w[0], 0);
    check("t1_mismatch", mis_w[0], 0);

    // AND gate against all-ones
    sweep(0, 1, 4'hF, n);
    check("t2_latency", n, 8);
    check("t2_table", tbl_w[0], 4'h8);
    check("t2_err", err_w[0], 3);
    check("t2_mismatch", mis_w[0], 1);
    repeat (3) @(negedge clk);
    check("t2_hold_table", tbl_w[0], 4'h8);
    check("t2_hold_mismatch", mis_w[0], 1);
    check("t2_hold_done", done_w[0], 0);

    // reset in the middle of a sweep
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    k = 0;
    while (stim_w[0] !== 2'd2 && k < 50) begin @(negedge clk); k++; end
    check("t3_reach_stim2", stim_w[0], 2);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("t3_stim", stim_w[0], 0);
    check("t3_table", tbl_w[0], 0);
    check("t3_busy", busy_w[0], 0);
    seen = 0;
    repeat (12) begin @(negedge clk); if (done_w[0] === 1'b1) seen++; end
    check("t3_no_done", seen, 0);
    sweep(0, 1, 4'hF, n);
    check("t3_resweep_latency", n, 8);

    // start held high through a sweep
    @(negedge clk);
    f_v[0] = gate_tt(1); exp_v[0] = 4'hF; start_v[0] = 1'b1;
    @(negedge clk);
    wait_done(0, n);
    check("t4_latency", n, 8);
    @(negedge clk);
    check("t4_idle_busy", busy_w[0], 0);
    check("t4_idle_done", done_w[0], 0);
    @(negedge clk);
    check("t4_reaccept_busy", busy_w[0], 1);
    check("t4_reaccept_table", tbl_w[0], 0);
    start_v[0] = 1'b0;
    wait_done(0, n);
    check("t4_second_latency", n, 8);

    // SETTLE=3, OR gate
    sweep(1, 2, 4'hE, n);
    check("t5_latency", n, 16);
    check("t5_table", tbl_w[1], 4'hE);
    check("t5_mismatch", mis_w[1], 0);

    // SETTLE=0, NOT x
    sweep(2, 3, 4'h3, n);
    check("t6_latency", n, 4);
    check("t6_table", tbl_w[2], 4'h3);
    check("t6_err", err_w[2], 0);

    // random gates, golden masks, start and reset pulses
    rand_dones = 0;
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        rst_v[i] = ($urandom_range(0, 199) == 0);
        if (!m[i].active && !m[i].in_done && $urandom_range(0, 1) == 1) begin
          f_v[i]   = 4'($urandom);
          exp_v[i] = 4'($urandom);
        end
        start_v[i] = ($urandom_range(0, 5) == 0);
      end
    end
    for (int i = 0; i < NI; i++) begin rst_v[i] = 1'b0; start_v[i] = 1'b0; end
    repeat (40) @(negedge clk);
    check("rand_done_seen", (rand_dones > 20) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
